// File: rtl/qspi_mem_arb_if.sv
// qspi_mem_arb_if
// Bundles the two requester ports (instruction fetch, data) and the QSPI
// pad signals of the shared memory controller.
//   slave  : view taken by qspi_mem_arb (requests and mem_sd_i in,
//            acks/rdata and pad drives out)
//   master : view taken by whatever drives the requests and models the
//            external memories
interface qspi_mem_arb_if;
    logic        instr_req_i;
    logic [23:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic        instr_ack_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [24:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        mem_cs_rom_on;
    logic        mem_cs_ram_on;
    logic        mem_sck_o;
    logic [3:0]  mem_sd_o;
    logic [3:0]  mem_sd_oen_o;
    logic [3:0]  mem_sd_i;

    modport slave (
        input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_addr_i,
               data_wdata_i, mem_sd_i,
        output instr_rdata_o, instr_ack_o, data_rdata_o, data_ack_o,
               mem_cs_rom_on, mem_cs_ram_on, mem_sck_o, mem_sd_o, mem_sd_oen_o
    );

    modport master (
        output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_addr_i,
               data_wdata_i, mem_sd_i,
        input  instr_rdata_o, instr_ack_o, data_rdata_o, data_ack_o,
               mem_cs_rom_on, mem_cs_ram_on, mem_sck_o, mem_sd_o, mem_sd_oen_o
    );
endinterface

// File: rtl/qspi_mem_arb.sv
// qspi_mem_arb
// Shared QPI memory controller: arbitrates the instruction-fetch and data
// ports onto one 4-bit bus, selects the ROM or RAM chip, and sequences
// command, 24-bit address, dummy (reads) and 32-bit little-endian data.
// Every nibble slot is two clk cycles: phase 0 drives sd_o with sck low,
// phase 1 raises sck, and read data is sampled on the edge ending phase 1.
// Ports:
//   clk_i  : clock
//   rst_in : synchronous active-low reset
//   bus    : qspi_mem_arb_if.slave (requester ports and mem_* pads)
// Build option: define MEM_ARB_DATA_PRIO_EN to give the data port fixed
// priority on simultaneous requests (no round-robin pointer).
module qspi_mem_arb #(
    parameter int ROM_DUMMY = 6,
    parameter int RAM_DUMMY = 6,
    parameter int CS_GAP    = 2
) (
    input logic           clk_i,
    input logic           rst_in,
    qspi_mem_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, XFER, ACK, GAP} state_t;

    state_t      state_reg, state_next;
    logic        pend_reg, pend_next;          // granted, bus sequence starts next cycle
    logic        sel_data_reg, sel_data_next;  // 1 = data port owns the transaction
    logic        we_reg, we_next;
    logic        ram_reg, ram_next;
    logic [23:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  nib_reg, nib_next;            // slot index within the current phase
    logic        ph_reg, ph_next;              // half of the nibble slot
    logic [3:0]  gap_reg, gap_next;
    logic [31:0] sh_reg, sh_next;              // received nibbles, first at the bottom
    logic [31:0] instr_rdata_reg, instr_rdata_next;
    logic [31:0] data_rdata_reg, data_rdata_next;
`ifndef MEM_ARB_DATA_PRIO_EN
    logic        last_data_reg, last_data_next;
`endif

    logic        grant_data;
    logic        rom_write;
    logic        dummy_zero;
    logic        active;
    logic [3:0]  nib_last;
    logic [31:0] sh_in;
    logic [31:0] rx_word;
    logic [7:0]  cmd_byte;
    logic [4:0]  addr_lsb;
    logic [4:0]  wdata_lsb;

`ifdef MEM_ARB_DATA_PRIO_EN
    assign grant_data = bus.data_req_i;
`else
    // Both pending: serve the port that was not served last.
    assign grant_data = bus.data_req_i && (!bus.instr_req_i || !last_data_reg);
`endif

    // Writes to ROM space are acknowledged without touching the bus.
    assign rom_write  = we_reg && !ram_reg;
    assign dummy_zero = ram_reg ? (RAM_DUMMY == 0) : (ROM_DUMMY == 0);
    assign active     = state_reg inside {CMD, ADDR, DUMMY, XFER};

    // Nibbles arrive byte 0 first, high nibble first; after eight shifts the
    // first nibble sits in [3:0], so each byte just needs its halves swapped.
    assign sh_in = {bus.mem_sd_i, sh_reg[31:4]};
    for (genvar gi = 0; gi < 4; gi++) begin : g_rx_swap
        assign rx_word[8*gi +: 8] = {sh_in[8*gi +: 4], sh_in[8*gi+4 +: 4]};
    end

    always_comb begin
        case (state_reg)
            CMD:     nib_last = 4'd1;
            ADDR:    nib_last = 4'd5;
            DUMMY:   nib_last = ram_reg ? 4'(RAM_DUMMY - 1) : 4'(ROM_DUMMY - 1);
            default: nib_last = 4'd7;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        pend_next        = pend_reg;
        sel_data_next    = sel_data_reg;
        we_next          = we_reg;
        ram_next         = ram_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        nib_next         = nib_reg;
        ph_next          = ph_reg;
        gap_next         = gap_reg;
        sh_next          = sh_reg;
        instr_rdata_next = instr_rdata_reg;
        data_rdata_next  = data_rdata_reg;
`ifndef MEM_ARB_DATA_PRIO_EN
        last_data_next   = last_data_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pend_reg) begin
                    pend_next  = 1'b0;
                    nib_next   = 4'd0;
                    ph_next    = 1'b0;
                    state_next = rom_write ? ACK : CMD;
                end else if (bus.instr_req_i || bus.data_req_i) begin
                    pend_next     = 1'b1;
                    sel_data_next = grant_data;
                    we_next       = grant_data && bus.data_we_i;
                    ram_next      = grant_data && bus.data_addr_i[24];
                    addr_next     = grant_data ? bus.data_addr_i[23:0] : bus.instr_addr_i;
                    wdata_next    = bus.data_wdata_i;
`ifndef MEM_ARB_DATA_PRIO_EN
                    last_data_next = grant_data;
`endif
                end
            end
            CMD, ADDR, DUMMY, XFER: begin
                ph_next = !ph_reg;
                if (ph_reg) begin
                    nib_next = nib_reg + 4'd1;
                    if (state_reg == XFER) sh_next = sh_in;
                    if (nib_reg == nib_last) begin
                        nib_next = 4'd0;
                        case (state_reg)
                            CMD:   state_next = ADDR;
                            ADDR:  state_next = (we_reg || dummy_zero) ? XFER : DUMMY;
                            DUMMY: state_next = XFER;
                            default: begin
                                state_next = ACK;
                                if (!we_reg) begin
                                    if (sel_data_reg) data_rdata_next  = rx_word;
                                    else              instr_rdata_next = rx_word;
                                end
                            end
                        endcase
                    end
                end
            end
            ACK: begin
                gap_next   = 4'd0;
                state_next = rom_write ? IDLE : GAP;
            end
            GAP: begin
                gap_next = gap_reg + 4'd1;
                if (gap_reg == 4'(CS_GAP - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_reg       <= IDLE;
            pend_reg        <= 1'b0;
            sel_data_reg    <= 1'b0;
            we_reg          <= 1'b0;
            ram_reg         <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            nib_reg         <= '0;
            ph_reg          <= 1'b0;
            gap_reg         <= '0;
            sh_reg          <= '0;
            instr_rdata_reg <= '0;
            data_rdata_reg  <= '0;
`ifndef MEM_ARB_DATA_PRIO_EN
            last_data_reg   <= 1'b1;  // pretend data went last so instr wins first
`endif
        end else begin
            state_reg       <= state_next;
            pend_reg        <= pend_next;
            sel_data_reg    <= sel_data_next;
            we_reg          <= we_next;
            ram_reg         <= ram_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            nib_reg         <= nib_next;
            ph_reg          <= ph_next;
            gap_reg         <= gap_next;
            sh_reg          <= sh_next;
            instr_rdata_reg <= instr_rdata_next;
            data_rdata_reg  <= data_rdata_next;
`ifndef MEM_ARB_DATA_PRIO_EN
            last_data_reg   <= last_data_next;
`endif
        end
    end

    // Pad drives decode directly from state so chip selects drop on the
    // same edge that leaves the active phases (including reset).
    assign cmd_byte  = we_reg ? 8'h38 : 8'hEB;
    assign addr_lsb  = 5'd20 - {nib_reg[2:0], 2'b00};
    assign wdata_lsb = {nib_reg[2:1], 3'b000} | {2'b00, !nib_reg[0], 2'b00};

    always_comb begin
        bus.mem_sd_o     = 4'h0;
        bus.mem_sd_oen_o = 4'h0;
        case (state_reg)
            CMD: begin
                bus.mem_sd_o     = nib_reg[0] ? cmd_byte[3:0] : cmd_byte[7:4];
                bus.mem_sd_oen_o = 4'hF;
            end
            ADDR: begin
                bus.mem_sd_o     = addr_reg[addr_lsb +: 4];
                bus.mem_sd_oen_o = 4'hF;
            end
            XFER: begin
                if (we_reg) begin
                    bus.mem_sd_o     = wdata_reg[wdata_lsb +: 4];
                    bus.mem_sd_oen_o = 4'hF;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_cs_rom_on = !(active && !ram_reg);
    assign bus.mem_cs_ram_on = !(active && ram_reg);
    assign bus.mem_sck_o     = active && ph_reg;
    assign bus.instr_ack_o   = (state_reg == ACK) && !sel_data_reg;
    assign bus.data_ack_o    = (state_reg == ACK) && sel_data_reg;
    assign bus.instr_rdata_o = instr_rdata_reg;
    assign bus.data_rdata_o  = data_rdata_reg;
endmodule

// File: tb/tb_qspi_mem_arb.sv
module tb_qspi_mem_arb;
    localparam int ROM_DUMMY = 6;
    localparam int RAM_DUMMY = 6;
    localparam int CS_GAP    = 2;
`ifdef MEM_ARB_DATA_PRIO_EN
    localparam bit DATA_PRIO = 1'b1;
`else
    localparam bit DATA_PRIO = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_i = ~clk_i;

    qspi_mem_arb_if bus();

    qspi_mem_arb #(.ROM_DUMMY(ROM_DUMMY), .RAM_DUMMY(RAM_DUMMY), .CS_GAP(CS_GAP)) dut (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    bit [7:0] ram_mem [bit [23:0]];

    function automatic logic [7:0] mem_byte(input bit ram, input logic [23:0] a);
        if (ram) return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
        case (a)
            24'h000100: return 8'hEF;
            24'h000101: return 8'hBE;
            24'h000102: return 8'hAD;
            24'h000103: return 8'hDE;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input bit ram, input logic [23:0] a);
        return {mem_byte(ram, a + 24'd3), mem_byte(ram, a + 24'd2),
                mem_byte(ram, a + 24'd1), mem_byte(ram, a)};
    endfunction

    // ---------------- expected bus activity ----------------
    typedef struct packed {
        logic [3:0] nib;
        logic [3:0] oen;
        logic       ram;
    } slot_t;

    slot_t exp_q[$];
    int    exp_len_q[$];

    function automatic slot_t mk(input logic [3:0] n, input logic [3:0] o, input logic r);
        slot_t s;
        s.nib = n; s.oen = o; s.ram = r;
        return s;
    endfunction

    task automatic push_txn(input bit ram, input bit we, input logic [23:0] a, input logic [31:0] wd);
        logic [7:0] c;
        logic [7:0] by;
        int d;
        c = we ? 8'h38 : 8'hEB;
        d = ram ? RAM_DUMMY : ROM_DUMMY;
        exp_q.push_back(mk(c[7:4], 4'hF, ram));
        exp_q.push_back(mk(c[3:0], 4'hF, ram));
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(a[23-4*i -: 4], 4'hF, ram));
        if (!we) for (int i = 0; i < d; i++) exp_q.push_back(mk(4'h0, 4'h0, ram));
        for (int k = 0; k < 8; k++) begin
            by = wd[8*(k/2) +: 8];
            if (we) exp_q.push_back(mk((k % 2 == 0) ? by[7:4] : by[3:0], 4'hF, ram));
            else    exp_q.push_back(mk(4'h0, 4'h0, ram));
        end
        exp_len_q.push_back(2 * (16 + (we ? 0 : d)));
    endtask

    // ---------------- compare process / memory responder ----------------
    int         slot = 0;
    int         cs_len = 0;
    int         idle_run = 0;
    bit         seen_pulse = 0;
    bit         abort = 0;
    bit         prev_iack = 0;
    bit         prev_dack = 0;
    logic [7:0] m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    bit         m_ram = 0;
    logic [3:0] wr_hi = 4'h0;

    always @(negedge clk_i) begin
        bit rom_l;
        bit ram_l;
        slot_t e;
        int xs;
        logic [7:0] b;
        rom_l = !bus.mem_cs_rom_on;
        ram_l = !bus.mem_cs_ram_on;
        check("cs_exclusive", 32'(rom_l & ram_l), 32'd0);
        if (bus.instr_ack_o) check("iack_width", 32'(prev_iack), 32'd0);
        if (bus.data_ack_o)  check("dack_width", 32'(prev_dack), 32'd0);
        prev_iack = bus.instr_ack_o;
        prev_dack = bus.data_ack_o;
        if (rom_l || ram_l) begin
            if (cs_len == 0) begin
                if (seen_pulse) check("cs_gap_ok", 32'(idle_run >= CS_GAP), 32'd1);
                m_ram = ram_l;
                slot  = 0;
            end
            cs_len++;
            idle_run = 0;
            if (bus.mem_sck_o) begin
                if (exp_q.size() == 0) begin
                    check("slot_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("slot%0d_dev", slot), 32'(ram_l), 32'(e.ram));
                    check($sformatf("slot%0d_oen", slot), 32'(bus.mem_sd_oen_o), 32'(e.oen));
                    if (e.oen != 4'h0)
                        check($sformatf("slot%0d_nib", slot), 32'(bus.mem_sd_o), 32'(e.nib));
                end
                if (slot < 2)      m_cmd  = {m_cmd[3:0], bus.mem_sd_o};
                else if (slot < 8) m_addr = {m_addr[19:0], bus.mem_sd_o};
                xs = slot - 8 - ((m_cmd == 8'hEB) ? (m_ram ? RAM_DUMMY : ROM_DUMMY) : 0);
                if (xs >= 0 && xs < 8) begin
                    b = mem_byte(m_ram, m_addr + 24'(xs / 2));
                    if (m_cmd == 8'hEB) begin
                        bus.mem_sd_i = (xs % 2 == 0) ? b[7:4] : b[3:0];
                    end else if (m_cmd == 8'h38 && m_ram) begin
                        if (xs % 2 == 0) wr_hi = bus.mem_sd_o;
                        else ram_mem[m_addr + 24'(xs / 2)] = {wr_hi, bus.mem_sd_o};
                    end
                end
                slot++;
            end
        end else begin
            check("sck_idle", 32'(bus.mem_sck_o), 32'd0);
            if (cs_len > 0) begin
                if (abort) abort = 0;
                else if (exp_len_q.size() > 0) check("cs_low_len", 32'(cs_len), 32'(exp_len_q.pop_front()));
                else check("cs_pulse_unexpected", 32'(cs_len), 32'd0);
                seen_pulse = 1;
                cs_len = 0;
            end
            idle_run++;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic do_fetch(input logic [23:0] a, output int lat, output logic [31:0] rd);
        int k;
        k = 0;
        bus.instr_addr_i = a;
        bus.instr_req_i  = 1'b1;
        do begin
            @(negedge clk_i);
            k++;
        end while (!bus.instr_ack_o && k < 300);
        if (!bus.instr_ack_o) check("fetch_timeout", 32'(bus.instr_ack_o), 32'd1);
        bus.instr_req_i = 1'b0;
        rd  = bus.instr_rdata_o;
        lat = k - 1;
        $display("txn fetch  addr=%h rdata=%h lat=%0d", a, rd, lat);
        repeat (4) @(negedge clk_i);
    endtask

    task automatic do_data(input bit we, input logic [24:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd);
        int k;
        k = 0;
        bus.data_we_i    = we;
        bus.data_addr_i  = a;
        bus.data_wdata_i = wd;
        bus.data_req_i   = 1'b1;
        do begin
            @(negedge clk_i);
            k++;
        end while (!bus.data_ack_o && k < 300);
        if (!bus.data_ack_o) check("data_timeout", 32'(bus.data_ack_o), 32'd1);
        bus.data_req_i = 1'b0;
        rd  = bus.data_rdata_o;
        lat = k - 1;
        $display("txn data   we=%0d addr=%h wdata=%h rdata=%h lat=%0d", we, a, wd, rd, lat);
        repeat (4) @(negedge clk_i);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [31:0] rd;
        int order[8];
        int n, ni, nd, k;
        bit ire, dre;

        bus.instr_req_i = 0; bus.instr_addr_i = '0;
        bus.data_req_i = 0; bus.data_we_i = 0; bus.data_addr_i = '0; bus.data_wdata_i = '0;
        bus.mem_sd_i = 4'h0;

        repeat (3) @(negedge clk_i);
        check("rst_cs_rom", 32'(bus.mem_cs_rom_on), 32'd1);
        check("rst_cs_ram", 32'(bus.mem_cs_ram_on), 32'd1);
        check("rst_sck", 32'(bus.mem_sck_o), 32'd0);
        check("rst_sd_o", 32'(bus.mem_sd_o), 32'd0);
        check("rst_oen", 32'(bus.mem_sd_oen_o), 32'd0);
        check("rst_acks", 32'({bus.instr_ack_o, bus.data_ack_o}), 32'd0);
        check("rst_irdata", bus.instr_rdata_o, 32'd0);
        check("rst_drdata", bus.data_rdata_o, 32'd0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_i);

        // ROM fetch
        push_txn(1'b0, 1'b0, 24'h000100, 32'd0);
        do_fetch(24'h000100, lat, rd);
        check("fetch_lat", 32'(lat), 32'd45);
        check("fetch_rdata_lit", rd, 32'hDEADBEEF);
        check("fetch_rdata_model", rd, mem_word(1'b0, 24'h000100));

        // RAM write then read-back
        push_txn(1'b1, 1'b1, 24'h000040, 32'h12345678);
        do_data(1'b1, 25'h1000040, 32'h12345678, lat, rd);
        check("ramwr_lat", 32'(lat), 32'd33);
        push_txn(1'b1, 1'b0, 24'h000040, 32'd0);
        do_data(1'b0, 25'h1000040, 32'd0, lat, rd);
        check("ramrd_lat", 32'(lat), 32'd45);
        check("ramrd_rdata_lit", rd, 32'h12345678);

        // ROM write: immediate ack, no bus activity, read data held
        do_data(1'b1, 25'h0000010, 32'hCAFEF00D, lat, rd);
        check("romwr_lat", 32'(lat), 32'd1);
        check("romwr_rdata_hold", rd, 32'h12345678);

        // Both ports requesting continuously, 4 transactions each
        for (int i = 0; i < 8; i++) begin
            bit dat;
            int idx;
            dat = DATA_PRIO ? (i < 4) : (i % 2 == 1);
            idx = DATA_PRIO ? (i % 4) : (i / 2);
            if (dat) push_txn(1'b1, 1'b1, 24'h000080 + 24'(4 * idx), 32'hC0DE0000 + 32'(idx));
            else     push_txn(1'b0, 1'b0, 24'h000200 + 24'(4 * idx), 32'd0);
        end
        n = 0; ni = 0; nd = 0; k = 0; ire = 0; dre = 0;
        bus.instr_addr_i = 24'h000200;
        bus.data_we_i = 1'b1; bus.data_addr_i = 25'h1000080; bus.data_wdata_i = 32'hC0DE0000;
        bus.instr_req_i = 1'b1;
        bus.data_req_i  = 1'b1;
        while ((ni < 4 || nd < 4) && k < 3000) begin
            @(negedge clk_i);
            k++;
            if (ire) begin
                bus.instr_addr_i = 24'h000200 + 24'(4 * ni);
                bus.instr_req_i  = 1'b1;
                ire = 0;
            end
            if (dre) begin
                bus.data_addr_i  = 25'h1000080 + 25'(4 * nd);
                bus.data_wdata_i = 32'hC0DE0000 + 32'(nd);
                bus.data_req_i   = 1'b1;
                dre = 0;
            end
            if (bus.instr_ack_o && n < 8) begin
                order[n] = 0; n++;
                check($sformatf("arb_fetch%0d_rdata", ni), bus.instr_rdata_o,
                      mem_word(1'b0, 24'h000200 + 24'(4 * ni)));
                $display("txn arb    port=instr n=%0d rdata=%h", ni, bus.instr_rdata_o);
                ni++;
                bus.instr_req_i = 1'b0;
                if (ni < 4) ire = 1;
            end
            if (bus.data_ack_o && n < 8) begin
                order[n] = 1; n++;
                $display("txn arb    port=data  n=%0d", nd);
                nd++;
                bus.data_req_i = 1'b0;
                if (nd < 4) dre = 1;
            end
        end
        check("arb_count", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < n) check($sformatf("arb_order%0d", i), 32'(order[i]),
                             DATA_PRIO ? 32'(i < 4) : 32'(i % 2));
        repeat (4) @(negedge clk_i);

        // Reset in the middle of the address phase
        push_txn(1'b0, 1'b0, 24'h000100, 32'd0);
        bus.instr_addr_i = 24'h000100;
        bus.instr_req_i  = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk_i);
        check("pre_rst_in_txn", 32'(bus.mem_cs_rom_on), 32'd0);
        abort = 1;
        exp_q.delete();
        exp_len_q.delete();
        rst_in = 1'b0;
        bus.instr_req_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_cs_rom", 32'(bus.mem_cs_rom_on), 32'd1);
        check("rst_mid_cs_ram", 32'(bus.mem_cs_ram_on), 32'd1);
        check("rst_mid_irdata", bus.instr_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("rst_mid_noack", 32'(bus.instr_ack_o | bus.data_ack_o), 32'd0);
        end
        $display("txn reset  during ADDR, fetch dropped");
        push_txn(1'b0, 1'b0, 24'h000100, 32'd0);
        do_fetch(24'h000100, lat, rd);
        check("post_rst_lat", 32'(lat), 32'd45);
        check("post_rst_rdata", rd, 32'hDEADBEEF);
        check("exp_q_drained", 32'(exp_q.size() + exp_len_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
